scroll_scheduler: RTL and testbench

- Sequencer for the two-line scrolling text banner: owns the horizontal base positions of line 1 (top) and line 2 (bottom) that feed the per-letter glyph mappers.
- Advances positions once per video frame at a selectable speed, inserts an idle gap after each pass, staggers line 2 behind line 1, and supports pause.
- Sits between the VGA timing generator (frame_start) and the banner renderer (base1/base2).

---
 rtl/scroll_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_scroll_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : scroll_scheduler
// Description : Sequencer for the two-line scrolling text banner. Owns the
//               horizontal base positions of line 1 (top) and line 2
//               (bottom), advances them once per video frame at a selectable
//               speed, holds each line off-screen for a gap after every pass,
//               staggers line 2 behind line 1 and supports pause.
// Ports       : clk          system clock
//               rst_n        asynchronous active-low reset
//               enable       banner switch, low forces both lines idle
//               frame_start  one-clk pulse per frame (start of v-blank)
//               pause        freeze positions and gap counters while high
//               speed[1:0]   0: 1px/2 frames, 1: 1px, 2: 2px, 3: 4px per frame
//               base1/base2  line x positions, 12-bit two's complement
//               vis1/vis2    line currently scrolling
//               wrap1/wrap2  one-clk pulse when a line completes a pass
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_scheduler #(
    parameter int SCREEN_W   = 640,
    parameter int LEN1       = 315,   // must be < 2048 - SCREEN_W
    parameter int LEN2       = 270,   // must be < 2048 - SCREEN_W
    parameter int GAP_FRAMES = 60,
    parameter int STAGGER    = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        pause,
    input  logic [1:0]  speed,
    output logic [11:0] base1,
    output logic [11:0] base2,
    output logic        vis1,
    output logic        vis2,
    output logic        wrap1,
    output logic        wrap2
);

    localparam int                     c_GAP_W    = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
    localparam logic [c_GAP_W-1:0]     c_GAP_LAST = c_GAP_W'(GAP_FRAMES - 1);
    localparam logic [11:0]            c_HOME     = 12'(SCREEN_W);
    localparam logic signed [12:0]     c_MIN1     = 13'(-LEN1);
    localparam logic signed [12:0]     c_MIN2     = 13'(-LEN2);
    localparam logic signed [12:0]     c_ARM_X    = 13'(SCREEN_W - STAGGER);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SCROLL = 2'd1;
    localparam logic [1:0] c_GAP    = 2'd2;

    logic [1:0]          r_st1;
    logic [1:0]          r_st2;
    logic [c_GAP_W-1:0]  r_gap1;
    logic [c_GAP_W-1:0]  r_gap2;
    logic                r_half;
    logic                r_armed2;

    logic                w_step;
    logic [2:0]          w_amt;
    logic signed [12:0]  w_sub1;
    logic signed [12:0]  w_sub2;
    logic                w_wrap1;
    logic                w_wrap2;
    logic                w_arm_hit;

    assign w_step = frame_start & ~pause;

    // Pixels moved on this step; speed 0 moves on every second step only.
    always_comb begin
        w_amt = 3'd0;
        case (speed)
            2'd0:    w_amt = {2'b00, r_half};
            2'd1:    w_amt = 3'd1;
            2'd2:    w_amt = 3'd2;
            default: w_amt = 3'd4;
        endcase
    end

    // One extra bit so that -LEN - 4 cannot wrap around to a positive value.
    assign w_sub1  = $signed({base1[11], base1}) - $signed({10'd0, w_amt});
    assign w_sub2  = $signed({base2[11], base2}) - $signed({10'd0, w_amt});
    assign w_wrap1 = (w_sub1 < c_MIN1);
    assign w_wrap2 = (w_sub2 < c_MIN2);

    // Arms on the same edge that line 1's new position crosses the threshold.
    assign w_arm_hit = (r_st1 != c_GAP) && !w_wrap1 && (w_sub1 <= c_ARM_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st1    <= c_IDLE;
            r_st2    <= c_IDLE;
            r_gap1   <= '0;
            r_gap2   <= '0;
            r_half   <= 1'b0;
            r_armed2 <= 1'b0;
            base1    <= c_HOME;
            base2    <= c_HOME;
            vis1     <= 1'b0;
            vis2     <= 1'b0;
            wrap1    <= 1'b0;
            wrap2    <= 1'b0;
        end else begin
            wrap1 <= 1'b0;
            wrap2 <= 1'b0;
            if (!enable) begin
                r_st1    <= c_IDLE;
                r_st2    <= c_IDLE;
                r_gap1   <= '0;
                r_gap2   <= '0;
                r_half   <= 1'b0;
                r_armed2 <= 1'b0;
                base1    <= c_HOME;
                base2    <= c_HOME;
                vis1     <= 1'b0;
                vis2     <= 1'b0;
            end else if (w_step) begin
                r_half <= ~r_half;
                if (w_arm_hit) begin
                    r_armed2 <= 1'b1;
                end

                // Line 1: the first step already moves it on-screen.
                case (r_st1)
                    c_IDLE: begin
                        r_st1 <= c_SCROLL;
                        vis1  <= 1'b1;
                        base1 <= w_sub1[11:0];
                    end
                    c_SCROLL: begin
                        if (w_wrap1) begin
                            r_st1  <= c_GAP;
                            r_gap1 <= '0;
                            base1  <= c_HOME;
                            vis1   <= 1'b0;
                            wrap1  <= 1'b1;
                        end else begin
                            base1 <= w_sub1[11:0];
                        end
                    end
                    c_GAP: begin
                        if (r_gap1 == c_GAP_LAST) begin
                            r_st1 <= c_SCROLL;
                            vis1  <= 1'b1;
                        end else begin
                            r_gap1 <= r_gap1 + c_GAP_W'(1);
                        end
                    end
                    default: begin
                        r_st1 <= c_IDLE;
                        base1 <= c_HOME;
                        vis1  <= 1'b0;
                    end
                endcase

                // Line 2: becomes visible at SCREEN_W once armed and starts
                // moving on the following step, same as leaving the gap.
                case (r_st2)
                    c_IDLE: begin
                        if (r_armed2) begin
                            r_st2 <= c_SCROLL;
                            vis2  <= 1'b1;
                        end
                    end
                    c_SCROLL: begin
                        if (w_wrap2) begin
                            r_st2  <= c_GAP;
                            r_gap2 <= '0;
                            base2  <= c_HOME;
                            vis2   <= 1'b0;
                            wrap2  <= 1'b1;
                        end else begin
                            base2 <= w_sub2[11:0];
                        end
                    end
                    c_GAP: begin
                        if (r_gap2 == c_GAP_LAST) begin
                            r_st2 <= c_SCROLL;
                            vis2  <= 1'b1;
                        end else begin
                            r_gap2 <= r_gap2 + c_GAP_W'(1);
                        end
                    end
                    default: begin
                        r_st2 <= c_IDLE;
                        base2 <= c_HOME;
                        vis2  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scroll_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_scheduler
// Description : Self-checking bench for scroll_scheduler. A frame-level
//               behavioural model tracks both banner lines; directed scenarios
//               plus a randomized run are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_scheduler;

    localparam int c_W    = 640;
    localparam int c_L1   = 315;
    localparam int c_L2   = 270;
    localparam int c_GAPF = 60;
    localparam int c_STAG = 200;

    localparam int P_IDLE   = 0;
    localparam int P_SCROLL = 1;
    localparam int P_GAP    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic        pause;
    logic [1:0]  speed;
    logic [11:0] base1;
    logic [11:0] base2;
    logic        vis1;
    logic        vis2;
    logic        wrap1;
    logic        wrap2;

    logic signed [11:0] sb1;
    logic signed [11:0] sb2;
    assign sb1 = base1;
    assign sb2 = base2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, one entry per line.
    int m_x   [2];
    int m_ph  [2];
    int m_cnt [2];
    bit m_w   [2];
    bit m_half;
    bit m_arm;

    scroll_scheduler #(
        .SCREEN_W   (c_W),
        .LEN1       (c_L1),
        .LEN2       (c_L2),
        .GAP_FRAMES (c_GAPF),
        .STAGGER    (c_STAG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_start (frame_start),
        .pause       (pause),
        .speed       (speed),
        .base1       (base1),
        .base2       (base2),
        .vis1        (vis1),
        .vis2        (vis2),
        .wrap1       (wrap1),
        .wrap2       (wrap2)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            m_x[k]   = c_W;
            m_ph[k]  = P_IDLE;
            m_cnt[k] = 0;
            m_w[k]   = 1'b0;
        end
        m_half = 1'b0;
        m_arm  = 1'b0;
    endfunction

    function automatic void model_clk(input bit en, input bit fs, input bit ps, input logic [1:0] spd);
        int  amt;
        int  len;
        bit  armed_before;
        m_w[0] = 1'b0;
        m_w[1] = 1'b0;
        if (!en) begin
            model_clear();
            return;
        end
        if (!fs || ps) return;
        amt          = (spd == 2'd0) ? (m_half ? 1 : 0) : (1 << (int'(spd) - 1));
        m_half       = !m_half;
        armed_before = m_arm;
        for (int k = 0; k < 2; k++) begin
            len = (k == 0) ? c_L1 : c_L2;
            if (m_ph[k] == P_IDLE) begin
                if (k == 0) begin
                    m_ph[k] = P_SCROLL;
                    m_x[k]  = m_x[k] - amt;
                end else if (armed_before) begin
                    m_ph[k] = P_SCROLL;
                end
            end else if (m_ph[k] == P_SCROLL) begin
                if (m_x[k] - amt < -len) begin
                    m_x[k]   = c_W;
                    m_w[k]   = 1'b1;
                    m_ph[k]  = P_GAP;
                    m_cnt[k] = 0;
                end else begin
                    m_x[k] = m_x[k] - amt;
                end
            end else begin
                if (m_cnt[k] == c_GAPF - 1) m_ph[k] = P_SCROLL;
                else                        m_cnt[k] = m_cnt[k] + 1;
            end
        end
        if (m_ph[0] == P_SCROLL && m_x[0] <= c_W - c_STAG) m_arm = 1'b1;
    endfunction

    // One clock: drive on the falling edge, step the model at the rising edge,
    // leave the caller 1 time unit after the edge to sample.
    task automatic cyc(input bit en, input bit fs, input bit ps, input logic [1:0] spd);
        @(negedge clk);
        enable      = en;
        frame_start = fs;
        pause       = ps;
        speed       = spd;
        @(posedge clk);
        model_clk(en, fs, ps, spd);
        #1;
    endtask

    task automatic frame(input bit ps, input logic [1:0] spd);
        repeat (3) cyc(1'b1, 1'b0, ps, spd);
        cyc(1'b1, 1'b1, ps, spd);
    endtask

    task automatic restart();
        cyc(1'b0, 1'b0, 1'b0, 2'd1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (base1 !== 12'd640) begin n_bad++; $display("FAIL reset.base1 got %0d want 640", sb1); end
        n_cmp++; if (base2 !== 12'd640) begin n_bad++; $display("FAIL reset.base2 got %0d want 640", sb2); end
        n_cmp++; if (vis1 !== 1'b0) begin n_bad++; $display("FAIL reset.vis1 got %b want 0", vis1); end
        n_cmp++; if (vis2 !== 1'b0) begin n_bad++; $display("FAIL reset.vis2 got %b want 0", vis2); end
        n_cmp++; if (wrap1 !== 1'b0) begin n_bad++; $display("FAIL reset.wrap1 got %b want 0", wrap1); end
        n_cmp++; if (wrap2 !== 1'b0) begin n_bad++; $display("FAIL reset.wrap2 got %b want 0", wrap2); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) frame(1'b0, 2'd1);
        n_cmp++; if (sb1 !== 12'(540)) begin n_bad++; $display("FAIL reset.pre_base1 got %0d want 540", sb1); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (base1 !== 12'd640) begin n_bad++; $display("FAIL reset.async_base1 got %0d want 640", sb1); end
        n_cmp++; if (base2 !== 12'd640) begin n_bad++; $display("FAIL reset.async_base2 got %0d want 640", sb2); end
        n_cmp++; if (vis1 !== 1'b0) begin n_bad++; $display("FAIL reset.async_vis1 got %b want 0", vis1); end
        model_clear();
        @(negedge clk);
        enable      = 1'b0;
        frame_start = 1'b0;
        rst_n       = 1'b1;
    endtask

    task automatic test_pass_timing();
        restart();
        for (int f = 1; f <= 1017; f++) begin
            frame(1'b0, 2'd1);
            n_cmp++; if (sb1 !== 12'(m_x[0])) begin n_bad++; $display("FAIL pass.base1 f=%0d got %0d want %0d", f, sb1, m_x[0]); end
            n_cmp++; if (vis1 !== (m_ph[0] == P_SCROLL)) begin n_bad++; $display("FAIL pass.vis1 f=%0d got %b want %b", f, vis1, m_ph[0] == P_SCROLL); end
            n_cmp++; if (wrap1 !== m_w[0]) begin n_bad++; $display("FAIL pass.wrap1 f=%0d got %b want %b", f, wrap1, m_w[0]); end
            if (f == 1) begin
                n_cmp++; if (vis1 !== 1'b1 || sb1 !== 12'(639)) begin n_bad++; $display("FAIL pass.first got vis1=%b base1=%0d want 1/639", vis1, sb1); end
            end
            if (f == 955) begin
                n_cmp++; if (sb1 !== 12'(-315)) begin n_bad++; $display("FAIL pass.last_pos got %0d want -315", sb1); end
            end
            if (f == 956) begin
                n_cmp++; if (wrap1 !== 1'b1 || sb1 !== 12'(640) || vis1 !== 1'b0) begin n_bad++; $display("FAIL pass.wrap got wrap1=%b base1=%0d vis1=%b want 1/640/0", wrap1, sb1, vis1); end
                cyc(1'b1, 1'b0, 1'b0, 2'd1);
                n_cmp++; if (wrap1 !== 1'b0) begin n_bad++; $display("FAIL pass.wrap_width got %b want 0", wrap1); end
            end
            if (f == 1015) begin
                n_cmp++; if (vis1 !== 1'b0) begin n_bad++; $display("FAIL pass.gap_end got vis1=%b want 0", vis1); end
            end
            if (f == 1016) begin
                n_cmp++; if (vis1 !== 1'b1 || sb1 !== 12'(640)) begin n_bad++; $display("FAIL pass.regap got vis1=%b base1=%0d want 1/640", vis1, sb1); end
            end
            if (f == 1017) begin
                n_cmp++; if (sb1 !== 12'(639)) begin n_bad++; $display("FAIL pass.second got %0d want 639", sb1); end
            end
        end
    endtask

    task automatic test_stagger();
        restart();
        for (int f = 1; f <= 202; f++) begin
            frame(1'b0, 2'd1);
            n_cmp++; if (sb2 !== 12'(m_x[1])) begin n_bad++; $display("FAIL stag.base2 f=%0d got %0d want %0d", f, sb2, m_x[1]); end
            n_cmp++; if (vis2 !== (m_ph[1] == P_SCROLL)) begin n_bad++; $display("FAIL stag.vis2 f=%0d got %b want %b", f, vis2, m_ph[1] == P_SCROLL); end
            if (f == 200) begin
                n_cmp++; if (sb1 !== 12'(440) || vis2 !== 1'b0) begin n_bad++; $display("FAIL stag.arm got base1=%0d vis2=%b want 440/0", sb1, vis2); end
            end
            if (f == 201) begin
                n_cmp++; if (vis2 !== 1'b1 || sb2 !== 12'(640)) begin n_bad++; $display("FAIL stag.enter got vis2=%b base2=%0d want 1/640", vis2, sb2); end
            end
            if (f == 202) begin
                n_cmp++; if (sb2 !== 12'(639)) begin n_bad++; $display("FAIL stag.move got %0d want 639", sb2); end
            end
        end
    endtask

    task automatic test_speed();
        restart();
        repeat (10) frame(1'b0, 2'd3);
        n_cmp++; if (sb1 !== 12'(600)) begin n_bad++; $display("FAIL speed.s3 got %0d want 600", sb1); end
        repeat (4) frame(1'b0, 2'd0);
        n_cmp++; if (sb1 !== 12'(598)) begin n_bad++; $display("FAIL speed.s0 got %0d want 598", sb1); end
        frame(1'b0, 2'd2);
        n_cmp++; if (sb1 !== 12'(596)) begin n_bad++; $display("FAIL speed.s2 got %0d want 596", sb1); end
        repeat (227) frame(1'b0, 2'd3);
        n_cmp++; if (sb1 !== 12'(-312)) begin n_bad++; $display("FAIL speed.prewrap got %0d want -312", sb1); end
        n_cmp++; if (sb2 !== 12'(m_x[1])) begin n_bad++; $display("FAIL speed.base2 got %0d want %0d", sb2, m_x[1]); end
        frame(1'b0, 2'd3);
        n_cmp++; if (sb1 !== 12'(640) || wrap1 !== 1'b1 || vis1 !== 1'b0) begin n_bad++; $display("FAIL speed.wrap got base1=%0d wrap1=%b vis1=%b want 640/1/0", sb1, wrap1, vis1); end
    endtask

    task automatic test_pause();
        logic [11:0] b1, b2;
        logic        v1, v2;
        restart();
        repeat (300) frame(1'b0, 2'd1);
        b1 = base1; b2 = base2; v1 = vis1; v2 = vis2;
        for (int f = 0; f < 50; f++) begin
            frame(1'b1, 2'd1);
            n_cmp++; if (base1 !== b1 || base2 !== b2 || vis1 !== v1 || vis2 !== v2) begin n_bad++; $display("FAIL pause.scroll f=%0d got %0d/%0d/%b/%b want %0d/%0d/%b/%b", f, sb1, sb2, vis1, vis2, $signed(b1), $signed(b2), v1, v2); end
        end
        frame(1'b0, 2'd1);
        n_cmp++; if (base1 !== b1 - 12'd1 || base2 !== b2 - 12'd1) begin n_bad++; $display("FAIL pause.resume got %0d/%0d want %0d/%0d", sb1, sb2, $signed(b1) - 1, $signed(b2) - 1); end
        repeat (679) frame(1'b0, 2'd1);
        n_cmp++; if (vis1 !== 1'b0 || sb1 !== 12'(640) || sb2 !== 12'(m_x[1])) begin n_bad++; $display("FAIL pause.gap_pre got vis1=%b base1=%0d base2=%0d want 0/640/%0d", vis1, sb1, sb2, m_x[1]); end
        b2 = base2; v2 = vis2;
        for (int f = 0; f < 50; f++) begin
            frame(1'b1, 2'd1);
            n_cmp++; if (vis1 !== 1'b0 || base1 !== 12'd640 || base2 !== b2 || vis2 !== v2) begin n_bad++; $display("FAIL pause.gap f=%0d got %b/%0d/%0d/%b want 0/640/%0d/%b", f, vis1, sb1, sb2, vis2, $signed(b2), v2); end
        end
        for (int k = 1; k <= 36; k++) begin
            frame(1'b0, 2'd1);
            n_cmp++; if (vis1 !== (k == 36)) begin n_bad++; $display("FAIL pause.gap_count k=%0d got vis1=%b want %b", k, vis1, k == 36); end
        end
    endtask

    task automatic test_enable_drop();
        restart();
        repeat (1120) frame(1'b0, 2'd1);
        n_cmp++; if (vis2 !== 1'b0 || vis1 !== 1'b1 || sb1 !== 12'(536)) begin n_bad++; $display("FAIL en.pre got vis2=%b vis1=%b base1=%0d want 0/1/536", vis2, vis1, sb1); end
        cyc(1'b0, 1'b1, 1'b0, 2'd1);
        n_cmp++; if (base1 !== 12'd640 || base2 !== 12'd640) begin n_bad++; $display("FAIL en.bases got %0d/%0d want 640/640", sb1, sb2); end
        n_cmp++; if (vis1 !== 1'b0 || vis2 !== 1'b0) begin n_bad++; $display("FAIL en.vis got %b/%b want 0/0", vis1, vis2); end
        n_cmp++; if (wrap1 !== 1'b0 || wrap2 !== 1'b0) begin n_bad++; $display("FAIL en.wrap got %b/%b want 0/0", wrap1, wrap2); end
        for (int f = 1; f <= 201; f++) begin
            frame(1'b0, 2'd1);
            n_cmp++; if (vis2 !== (f == 201)) begin n_bad++; $display("FAIL en.restagger f=%0d got vis2=%b want %b", f, vis2, f == 201); end
            n_cmp++; if (sb1 !== 12'(m_x[0])) begin n_bad++; $display("FAIL en.base1 f=%0d got %0d want %0d", f, sb1, m_x[0]); end
        end
    endtask

    task automatic test_random();
        logic [1:0] spd;
        bit en, fs, ps;
        spd = 2'd0;
        restart();
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 299) != 0);
            fs = ($urandom_range(0, 2) == 0);
            ps = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) spd = 2'($urandom);
            cyc(en, fs, ps, spd);
            n_cmp++; if (sb1 !== 12'(m_x[0])) begin n_bad++; $display("FAIL rnd.base1 i=%0d got %0d want %0d", i, sb1, m_x[0]); end
            n_cmp++; if (sb2 !== 12'(m_x[1])) begin n_bad++; $display("FAIL rnd.base2 i=%0d got %0d want %0d", i, sb2, m_x[1]); end
            n_cmp++; if (vis1 !== (m_ph[0] == P_SCROLL)) begin n_bad++; $display("FAIL rnd.vis1 i=%0d got %b want %b", i, vis1, m_ph[0] == P_SCROLL); end
            n_cmp++; if (vis2 !== (m_ph[1] == P_SCROLL)) begin n_bad++; $display("FAIL rnd.vis2 i=%0d got %b want %b", i, vis2, m_ph[1] == P_SCROLL); end
            n_cmp++; if (wrap1 !== m_w[0]) begin n_bad++; $display("FAIL rnd.wrap1 i=%0d got %b want %b", i, wrap1, m_w[0]); end
            n_cmp++; if (wrap2 !== m_w[1]) begin n_bad++; $display("FAIL rnd.wrap2 i=%0d got %b want %b", i, wrap2, m_w[1]); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        frame_start = 1'b0;
        pause       = 1'b0;
        speed       = 2'd0;
        test_reset();
        test_pass_timing();
        test_stagger();
        test_speed();
        test_pause();
        test_enable_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
